// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller:
// forwarding selects, FSM states and the hard-wired zero register.
package pipe_hazard_ctrl_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Per-operand forwarding compare against the MEM and WB stages.
// MEM wins over WB; loads in MEM have no data yet.
module pipe_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       i_mem_valid,
  input  logic       i_mem_we,
  input  logic       i_mem_mr,
  input  logic [4:0] i_mem_rd,
  input  logic       i_wb_valid,
  input  logic       i_wb_we,
  input  logic [4:0] i_wb_rd,
  input  logic [4:0] i_rs,
  output logic [1:0] o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_valid & i_mem_we & ~i_mem_mr &
                     (i_mem_rd != REG_X0) & (i_mem_rd == i_rs);
  assign w_wb_hit  = i_wb_valid & i_wb_we &
                     (i_wb_rd != REG_X0) & (i_wb_rd == i_rs);

  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit)
      o_sel = FWD_EXMEM;
    else if (w_wb_hit)
      o_sel = FWD_MEMWB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage RV32I pipe:
// enables, bubbles, flushes, forwarding and DMEM freeze.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             ex_branch_taken,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WMAX = '1;
  localparam logic [WCW-1:0] WLIM = WCW'(MEM_TIMEOUT - 1);

  hz_state_e r_state, w_state_nxt;

  logic       r_ex_valid, r_ex_we, r_ex_mr, r_ex_mw;
  logic [4:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
  logic       r_mem_valid, r_mem_we, r_mem_mr, r_mem_mw;
  logic [4:0] r_mem_rd;
  logic       r_wb_valid, r_wb_we;
  logic [4:0] r_wb_rd;

  logic [WCW-1:0]   r_wcnt;
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_freeze, w_luse, w_flush, w_stall, w_bubble, w_hit;

  assign w_freeze = r_mem_valid & (r_mem_mr | r_mem_mw) & ~dmem_ready;
  assign w_luse   = r_ex_valid & r_ex_mr & (r_ex_rd != REG_X0) & id_valid &
                    ((id_rs1_used & (id_rs1 == r_ex_rd)) |
                     (id_rs2_used & (id_rs2 == r_ex_rd)));
  assign w_flush  = ~w_freeze & ex_branch_taken;
  assign w_stall  = ~w_freeze & ~ex_branch_taken & w_luse;
  assign w_bubble = w_flush | w_stall;
  // Raised combinationally so the timeout shows in the cycle it is reached
  assign w_hit    = w_freeze & (r_wcnt >= WLIM);

  assign mem_err   = r_err | w_hit;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_comb begin
    w_state_nxt = r_state;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    unique case (r_state)
      ST_RUN:     if (w_freeze) w_state_nxt = ST_MEMWAIT;
      ST_MEMWAIT: if (dmem_ready) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
    if (w_freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_luse) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wcnt      <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | w_hit;
      if (w_freeze) begin
        if (r_wcnt != WMAX) r_wcnt <= r_wcnt + 1'b1;
      end else begin
        r_wcnt <= '0;
      end
      if (w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_ex_mw     <= 1'b0;
      r_ex_rd     <= '0;
      r_ex_rs1    <= '0;
      r_ex_rs2    <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_mr    <= 1'b0;
      r_mem_mw    <= 1'b0;
      r_mem_rd    <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= '0;
    end else if (!w_freeze) begin
      r_mem_valid <= r_ex_valid;
      r_mem_we    <= r_ex_we;
      r_mem_mr    <= r_ex_mr;
      r_mem_mw    <= r_ex_mw;
      r_mem_rd    <= r_ex_rd;
      r_wb_valid  <= r_mem_valid;
      r_wb_we     <= r_mem_we;
      r_wb_rd     <= r_mem_rd;
      if (w_bubble) begin
        r_ex_valid <= 1'b0;
        r_ex_we    <= 1'b0;
        r_ex_mr    <= 1'b0;
        r_ex_mw    <= 1'b0;
        r_ex_rd    <= '0;
        r_ex_rs1   <= '0;
        r_ex_rs2   <= '0;
      end else begin
        r_ex_valid <= id_valid;
        r_ex_we    <= id_regwrite;
        r_ex_mr    <= id_memread;
        r_ex_mw    <= id_memwrite;
        r_ex_rd    <= id_rd;
        r_ex_rs1   <= id_rs1;
        r_ex_rs2   <= id_rs2;
      end
    end
  end

  pipe_fwd_unit u_fwd_a (
    .i_mem_valid (r_mem_valid),
    .i_mem_we    (r_mem_we),
    .i_mem_mr    (r_mem_mr),
    .i_mem_rd    (r_mem_rd),
    .i_wb_valid  (r_wb_valid),
    .i_wb_we     (r_wb_we),
    .i_wb_rd     (r_wb_rd),
    .i_rs        (r_ex_rs1),
    .o_sel       (fwd_a_sel)
  );

  pipe_fwd_unit u_fwd_b (
    .i_mem_valid (r_mem_valid),
    .i_mem_we    (r_mem_we),
    .i_mem_mr    (r_mem_mr),
    .i_mem_rd    (r_mem_rd),
    .i_wb_valid  (r_wb_valid),
    .i_wb_we     (r_wb_we),
    .i_wb_rd     (r_wb_rd),
    .i_rs        (r_ex_rs2),
    .o_sel       (fwd_b_sel)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use,
// branch flush, DMEM freeze/timeout and reset during MEMWAIT.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        ex_branch_taken;
  logic        dmem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        mem_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic [6:0]  ctl;

  int errors = 0;
  int checks = 0;

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_memwrite     (id_memwrite),
    .ex_branch_taken (ex_branch_taken),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .mem_err         (mem_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_memwrite = mw;
  endtask

  task automatic nop();
    id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ex_branch_taken = 1'b0;
    dmem_ready = 1'b1;
    nop();
    tick();
    tick();
    rst = 1'b0;

    // reset state
    settle();
    chk("rst_ctl", 32'(ctl), 32'h7C);
    chk("rst_fwd_a", 32'(fwd_a_sel), 32'h0);
    chk("rst_fwd_b", 32'(fwd_b_sel), 32'h0);
    chk("rst_stall", stall_cnt, 32'h0);
    chk("rst_flush", flush_cnt, 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    tick();

    // add x5 ; add x6,x5,x3 -> EX/MEM forward on A
    id_set(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    tick();
    id_set(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0, 0);
    settle();
    chk("alu_dep_ctl", 32'(ctl), 32'h7C);
    tick();
    nop();
    settle();
    chk("fwd_a_exmem", 32'(fwd_a_sel), 32'h1);
    chk("fwd_b_none", 32'(fwd_b_sel), 32'h0);
    tick();

    // add x8 ; nop ; add x9,x8 -> MEM/WB forward on A
    id_set(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 0);
    tick();
    nop();
    tick();
    id_set(1, 5'd8, 5'd3, 1, 1, 5'd9, 1, 0, 0);
    tick();
    nop();
    settle();
    chk("fwd_a_memwb", 32'(fwd_a_sel), 32'h2);
    tick();

    // rd = x0 producer never forwards
    id_set(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0);
    tick();
    id_set(1, 5'd0, 5'd4, 1, 1, 5'd10, 1, 0, 0);
    tick();
    nop();
    settle();
    chk("fwd_a_x0", 32'(fwd_a_sel), 32'h0);
    tick();

    // same rd in MEM and WB -> MEM wins
    id_set(1, 5'd1, 5'd2, 1, 1, 5'd11, 1, 0, 0);
    tick();
    id_set(1, 5'd3, 5'd4, 1, 1, 5'd11, 1, 0, 0);
    tick();
    id_set(1, 5'd0, 5'd11, 1, 1, 5'd12, 1, 0, 0);
    tick();
    nop();
    settle();
    chk("fwd_b_mem_prio", 32'(fwd_b_sel), 32'h1);
    tick();

    // lw x5 ; add x6,x0,x5 -> one stall cycle
    id_set(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
    tick();
    id_set(1, 5'd0, 5'd5, 1, 1, 5'd6, 1, 0, 0);
    settle();
    chk("luse_ctl", 32'(ctl), 32'h1D);
    tick();
    settle();
    chk("luse_after_ctl", 32'(ctl), 32'h7C);
    chk("luse_stall_cnt", stall_cnt, 32'h1);
    tick();
    nop();
    settle();
    chk("luse_fwd_b", 32'(fwd_b_sel), 32'h2);
    chk("luse_fwd_a", 32'(fwd_a_sel), 32'h0);
    tick();

    // taken branch
    ex_branch_taken = 1'b1;
    settle();
    chk("br_ctl", 32'(ctl), 32'h7F);
    tick();
    ex_branch_taken = 1'b0;
    settle();
    chk("br_flush_cnt", flush_cnt, 32'h1);
    chk("br_after_ctl", 32'(ctl), 32'h7C);
    tick();

    // branch coincident with load-use: flush wins, no stall counted
    id_set(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 0);
    tick();
    id_set(1, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0, 0);
    ex_branch_taken = 1'b1;
    settle();
    chk("br_luse_ctl", 32'(ctl), 32'h7F);
    tick();
    ex_branch_taken = 1'b0;
    nop();
    settle();
    chk("br_luse_stall", stall_cnt, 32'h1);
    chk("br_luse_flush", flush_cnt, 32'h2);
    chk("br_luse_after", 32'(ctl), 32'h7C);
    tick();

    // DMEM wait of 3 cycles, state held across the freeze
    id_set(1, 5'd1, 5'd0, 1, 0, 5'd12, 1, 1, 0);
    tick();
    id_set(1, 5'd1, 5'd2, 1, 1, 5'd13, 1, 0, 0);
    tick();
    id_set(1, 5'd13, 5'd0, 1, 0, 5'd14, 1, 0, 0);
    dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("frz3_ctl_%0d", k), 32'(ctl), 32'h0);
      chk($sformatf("frz3_err_%0d", k), 32'(mem_err), 32'h0);
      tick();
    end
    dmem_ready = 1'b1;
    settle();
    chk("frz3_resume_ctl", 32'(ctl), 32'h7C);
    chk("frz3_err", 32'(mem_err), 32'h0);
    chk("frz3_stall", stall_cnt, 32'h1);
    chk("frz3_flush", flush_cnt, 32'h2);
    tick();
    nop();
    settle();
    chk("frz3_fwd_a", 32'(fwd_a_sel), 32'h1);
    tick();

    // DMEM wait of 6 cycles with MEM_TIMEOUT=4
    id_set(1, 5'd1, 5'd0, 1, 0, 5'd15, 1, 1, 0);
    tick();
    nop();
    tick();
    dmem_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("to_ctl_%0d", k), 32'(ctl), 32'h0);
      chk($sformatf("to_err_%0d", k), 32'(mem_err),
          (k >= 3) ? 32'h1 : 32'h0);
      tick();
    end
    dmem_ready = 1'b1;
    settle();
    chk("to_resume_ctl", 32'(ctl), 32'h7C);
    chk("to_err_sticky0", 32'(mem_err), 32'h1);
    tick();
    settle();
    chk("to_err_sticky1", 32'(mem_err), 32'h1);
    tick();

    // reset pulsed during MEMWAIT
    id_set(1, 5'd1, 5'd0, 1, 0, 5'd16, 1, 1, 0);
    tick();
    nop();
    tick();
    dmem_ready = 1'b0;
    settle();
    chk("rw_frz_ctl0", 32'(ctl), 32'h0);
    tick();
    settle();
    chk("rw_frz_ctl1", 32'(ctl), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rw_ctl", 32'(ctl), 32'h7C);
    chk("rw_stall", stall_cnt, 32'h0);
    chk("rw_flush", flush_cnt, 32'h0);
    chk("rw_err", 32'(mem_err), 32'h0);
    chk("rw_fwd_a", 32'(fwd_a_sel), 32'h0);
    tick();
    settle();
    chk("rw_ctl_next", 32'(ctl), 32'h7C);
    dmem_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
